// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the access-size encodings, the control FSM state enum, the registered
// request payload and the misalignment check used at acceptance.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  // Request fields still needed after acceptance.
  typedef struct packed {
    size_e            size;
    logic             sgn;
    logic [1:0]       offset;
    logic [XLEN-1:0]  wdata;
  } lsu_req_t;

  // Size 11 is never legal; halfwords need even, words need 4-byte alignment.
  function automatic logic misaligned(input size_e size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and data-memory signals of the load/store unit.
// slave : the unit's view (takes req_* and mem_read_data, drives the rest).
// master: the CPU/memory side view.
interface lsu_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [SIZE_W-1:0] req_size;
  logic              req_signed;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_error;
  logic [XLEN-1:0]   mem_address;
  logic [XLEN-1:0]   mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [XLEN-1:0]   mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational big-endian lane handling.
// Ports: size/sgn/offset describe the access; rdata is the memory word;
// wdata is right-justified store data; load_data is the extracted and
// extended lane; merge_data is rdata with the addressed lane(s) replaced.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e           size,
  input  logic            sgn,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);

  logic [4:0]  byte_shamt;
  logic [4:0]  half_shamt;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Offset 0 is the most significant lane, so the shift is (3-offset)*8
  // for bytes and (2-offset)*8 for halfwords.
  always_comb begin
    byte_shamt = {~offset, 3'b000};
    half_shamt = {~offset[1], 4'b0000};
    byte_val   = 8'(rdata >> byte_shamt);
    half_val   = 16'(rdata >> half_shamt);
    load_data  = rdata;
    merge_data = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data  = {{24{sgn & byte_val[7]}}, byte_val};
        merge_data = (rdata & ~(32'h0000_00FF << byte_shamt))
                   | (32'(wdata[7:0]) << byte_shamt);
      end
      SIZE_HALF: begin
        load_data  = {{16{sgn & half_val[15]}}, half_val};
        merge_data = (rdata & ~(32'h0000_FFFF << half_shamt))
                   | (32'(wdata[15:0]) << half_shamt);
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-organised data memory.
// Ports: clk, rst_n (async active-low), bus (lsu_if.slave) carrying the
// req/resp handshake and the mem_* word interface.
// Loads read one word and return the extended lane; word stores write
// directly; byte/half stores do a read-modify-write; misaligned requests
// respond with an error without touching memory.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  state_e          state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_error_q, resp_error_d;
  logic            accept;
  size_e           acc_size;
  logic            acc_bad;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merge_data;

  lsu_align u_align (
    .size       (req_q.size),
    .sgn        (req_q.sgn),
    .offset     (req_q.offset),
    .rdata      (bus.mem_read_data),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    accept   = bus.req_valid && (state_q == ST_IDLE);
    acc_size = size_e'(bus.req_size);
    acc_bad  = misaligned(acc_size, bus.req_addr[1:0]);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d   = '{size: acc_size, sgn: bus.req_signed,
                      offset: bus.req_addr[1:0], wdata: bus.req_wdata};
          addr_d  = {bus.req_addr[31:2], 2'b00};
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = acc_bad;
          if (acc_bad)                   state_d = ST_RESP;
          else if (!bus.req_write)       state_d = ST_LOAD;
          else if (acc_size == SIZE_WORD) state_d = ST_WRITE;
          else                           state_d = ST_RMW_READ;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        wdata_d = merge_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Strobes follow the state being entered so they line up with it.
    mem_read_d   = (state_d == ST_LOAD) || (state_d == ST_RMW_READ);
    mem_write_d  = (state_d == ST_WRITE);
    resp_valid_d = (state_d == ST_RESP);
    resp_error_d = (state_d == ST_RESP) && err_d;
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Ready is gated by rst_n so a request lands on the first edge after reset.
  assign bus.req_ready      = rst_n && (state_q == ST_IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lsu_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:255];
  assign bus.mem_read_data = mem[bus.mem_address[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_write_data;

  int rd_cycles = 0, wr_cycles = 0, overlap_cycles = 0, resp_cycles = 0;
  always @(negedge clk) begin
    if (bus.mem_read) rd_cycles++;
    if (bus.mem_write) wr_cycles++;
    if (bus.mem_read && bus.mem_write) overlap_cycles++;
    if (bus.resp_valid) resp_cycles++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and measure edges from acceptance to the response.
  task automatic do_req(input logic w, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    int waited;
    waited = 0;
    lat = 0; rdata = '0; err = 1'b0;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_write = w; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = i; rdata = bus.resp_rdata; err = bus.resp_error;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_mem;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int lat, rd0, wr0, resp0, r1_at, r2_at;
    logic [31:0] rdata, r1_data, r2_data;
    logic err;

    vecs[0]  = '{"lb_41",   1'b0, 2'b00, 1'b1, 32'h41, 32'h0,        32'hFFFFFF99, 1'b0, 2, 32'h8899AABB, 1, 0};
    vecs[1]  = '{"lhu_42",  1'b0, 2'b01, 1'b0, 32'h42, 32'h0,        32'h0000AABB, 1'b0, 2, 32'h8899AABB, 1, 0};
    vecs[2]  = '{"lh_40",   1'b0, 2'b01, 1'b1, 32'h40, 32'h0,        32'hFFFF8899, 1'b0, 2, 32'h8899AABB, 1, 0};
    vecs[3]  = '{"lbu_43",  1'b0, 2'b00, 1'b0, 32'h43, 32'h0,        32'h000000BB, 1'b0, 2, 32'h8899AABB, 1, 0};
    vecs[4]  = '{"lw_40",   1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h8899AABB, 1'b0, 2, 32'h8899AABB, 1, 0};
    vecs[5]  = '{"sb_82",   1'b1, 2'b00, 1'b0, 32'h82, 32'h000000EE, 32'h0,        1'b0, 3, 32'h1122EE44, 1, 1};
    vecs[6]  = '{"sb_80",   1'b1, 2'b00, 1'b0, 32'h80, 32'hFFFFFF01, 32'h0,        1'b0, 3, 32'h0122EE44, 1, 1};
    vecs[7]  = '{"sh_82",   1'b1, 2'b01, 1'b0, 32'h82, 32'h12345678, 32'h0,        1'b0, 3, 32'h01225678, 1, 1};
    vecs[8]  = '{"sw_86",   1'b1, 2'b10, 1'b0, 32'h86, 32'h55555555, 32'h0,        1'b1, 1, 32'h00000000, 0, 0};
    vecs[9]  = '{"lh_41",   1'b0, 2'b01, 1'b1, 32'h41, 32'h0,        32'h0,        1'b1, 1, 32'h8899AABB, 0, 0};
    vecs[10] = '{"size11",  1'b0, 2'b11, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1, 1, 32'h8899AABB, 0, 0};
    vecs[11] = '{"sw_84",   1'b1, 2'b10, 1'b0, 32'h84, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF, 0, 1};
    vecs[12] = '{"lb_87",   1'b0, 2'b00, 1'b1, 32'h87, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 32'hDEADBEEF, 1, 0};
    vecs[13] = '{"lhu_84",  1'b0, 2'b01, 1'b0, 32'h84, 32'h0,        32'h0000DEAD, 1'b0, 2, 32'hDEADBEEF, 1, 0};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[32'h40 >> 2] = 32'h8899AABB;
    mem[32'h80 >> 2] = 32'h11223344;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset values while rst_n is low.
    #12;
    check("rst_req_ready",  32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_error", 32'(bus.resp_error), 32'd0);
    check("rst_mem_read",   32'(bus.mem_read), 32'd0);
    check("rst_mem_write",  32'(bus.mem_write), 32'd0);
    check("rst_mem_addr",   bus.mem_address, 32'd0);
    check("rst_mem_wdata",  bus.mem_write_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Table-driven single accesses.
    for (int v = 0; v < 14; v++) begin
      rd0 = rd_cycles; wr0 = wr_cycles; resp0 = resp_cycles;
      do_req(vecs[v].w, vecs[v].size, vecs[v].sgn, vecs[v].addr, vecs[v].wdata, lat, rdata, err);
      @(negedge clk);
      check({vecs[v].name, "_lat"},   32'(lat), 32'(vecs[v].exp_lat));
      check({vecs[v].name, "_rdata"}, rdata, vecs[v].exp_rdata);
      check({vecs[v].name, "_err"},   32'(err), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_mem"},   mem[vecs[v].addr[9:2]], vecs[v].exp_mem);
      check({vecs[v].name, "_reads"}, 32'(rd_cycles - rd0), 32'(vecs[v].exp_rd));
      check({vecs[v].name, "_writes"}, 32'(wr_cycles - wr0), 32'(vecs[v].exp_wr));
      check({vecs[v].name, "_resps"}, 32'(resp_cycles - resp0), 32'd1);
    end

    // Reset pulsed during RMW_READ of a halfword store: no write, no response.
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'b01; bus.req_signed = 1'b0;
    bus.req_addr = 32'h80; bus.req_wdata = 32'h0000AAAA; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("rmw_read_active", 32'(bus.mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_mem_read",  32'(bus.mem_read), 32'd0);
    check("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
    wr0 = wr_cycles; resp0 = resp_cycles;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rstmid_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("rstmid_no_write", 32'(wr_cycles - wr0), 32'd0);
    check("rstmid_no_resp",  32'(resp_cycles - resp0), 32'd0);
    check("rstmid_mem",      mem[32'h80 >> 2], 32'h01225678);

    // Back-to-back sw then lw with req_valid held high; sw lands on first edge after reset.
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h100; bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 begin bus.req_write = 1'b0; bus.req_wdata = 32'h0; end
    r1_at = -1; r2_at = -1; r1_data = '1; r2_data = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) check("b2b_busy1", 32'(bus.req_ready), 32'd0);
      if (i == 2) check("b2b_busy2", 32'(bus.req_ready), 32'd0);
      if (i == 3) check("b2b_idle3", 32'(bus.req_ready), 32'd1);
      if (i == 4) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        if (r1_at < 0) begin r1_at = i; r1_data = bus.resp_rdata; end
        else if (r2_at < 0) begin r2_at = i; r2_data = bus.resp_rdata; end
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_sw_lat",   32'(r1_at), 32'd2);
    check("b2b_sw_rdata", r1_data, 32'd0);
    check("b2b_lw_at",    32'(r2_at), 32'd5);
    check("b2b_lw_rdata", r2_data, 32'hCAFEF00D);
    check("b2b_mem",      mem[32'h100 >> 2], 32'hCAFEF00D);
    check("no_rd_wr_overlap", 32'(overlap_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: none; data memory is word-organised, and each memory word is selected by address>>2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE with rst_n high.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as misaligned.
REQ-008 req_signed  input  1  loads only; 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  output  1  qualified by resp_valid; misaligned or illegal-size request.
REQ-014 mem_address  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 mem_write_data  output  32  full word to memory.
REQ-016 mem_write  output  1  memory writes the word on the next rising edge.
REQ-017 mem_read  output  1  read enable; memory returns mem_read_data combinationally in the same cycle.
REQ-018 mem_read_data  input  32  word from memory.

Function
REQ-019 A request is accepted on a rising edge where req_valid and req_ready are both high; all req_* fields are registered at acceptance.
REQ-020 FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-021 IDLE->LOAD on an accepted aligned load; IDLE->WRITE on an aligned word store; IDLE->RMW_READ on an aligned byte or half store; IDLE->RESP on a misaligned request.
REQ-022 LOAD: mem_read=1; the extracted, extended lane is registered; next state RESP.
REQ-023 RMW_READ: mem_read=1; mem_read_data is registered; next state WRITE.
REQ-024 WRITE: mem_write=1 for exactly one cycle, with the merged word, or with req_wdata for word stores; next state RESP.
REQ-025 RESP: resp_valid=1 for one cycle; next state IDLE; there is no response backpressure.
REQ-026 Latency from acceptance edge to resp_valid: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, misaligned 1 cycle.
REQ-027 Byte lanes are big-endian: offset 0 is bits [31:24], offset 3 is bits [7:0]; halfword offset 0 is [31:16] and offset 2 is [15:0].
REQ-028 Misaligned conditions: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11; these set resp_error=1 and issue no mem_read or mem_write.
REQ-029 Sub-word store merge replaces only the addressed lane(s) with the low bits of req_wdata; all other lanes keep the value read in RMW_READ.
REQ-030 mem_read and mem_write are never high in the same cycle and are 0 outside LOAD, RMW_READ and WRITE.
REQ-031 mem_address and mem_write_data hold their registered values while in any non-IDLE state.
REQ-032 req_valid while busy is ignored, because req_ready is low; there is no queuing.

Reset
REQ-033 Asserting rst_n low forces IDLE immediately, asynchronously, including mid-operation; a pending RMW write is abandoned and no partial write occurs.
REQ-034 Reset values: resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, req_ready=0 while rst_n low.
REQ-035 The first request can be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-036 Shared package lsu_pkg holds the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the FSM state enum and a misalignment-check function.
REQ-037 Combinational sub-module lsu_align performs lane extraction with extension and lane merge; the FSM and registers stay in load_store_unit.

Verification
REQ-038 Word 0x40 holds 0x8899AABB; lb at 0x41 signed -> resp_rdata 0xFFFFFF99, resp_valid 2 cycles after acceptance.
REQ-039 Same word; lhu at 0x42 -> resp_rdata 0x0000AABB; lh at 0x40 -> 0xFFFF8899.
REQ-040 Word 0x80 holds 0x11223344; sb at 0x82 with wdata 0x000000EE -> memory word becomes 0x1122EE44, resp_valid 3 cycles after acceptance, exactly one mem_write pulse.
REQ-041 sw at 0x86 -> resp_error=1, resp_valid 1 cycle after acceptance, with no mem_read or mem_write observed.
REQ-042 sh at 0x80 with rst_n pulsed low during RMW_READ -> the memory word is unchanged, req_ready is 1 on the first cycle after rst_n deasserts, and no resp_valid pulse occurs.
REQ-043 Back-to-back sw 0x100=0xCAFEF00D then lw 0x100 with req_valid held high -> the second request is accepted only in IDLE and returns 0xCAFEF00D.
